// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and helpers used by the instruction encoder
// and the fetch stage.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;
  localparam logic [3:0] RNONE  = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

  // Instruction length in bytes; 0 marks an illegal icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      HALT, NOP, RET:              instr_len = 4'd1;
      CMOVXX, OPQ, PUSHQ, POPQ:    instr_len = 4'd2;
      JXX, CALL:                   instr_len = 4'd9;
      IRMOVQ, RMMOVQ, MRMOVQ:      instr_len = 4'd10;
      default:                     instr_len = 4'd0;
    endcase
  endfunction

  // Byte idx of the encoded image; valC is stored most significant byte first.
  function automatic logic [7:0] instr_byte(input logic [3:0]  icode,
                                            input logic [3:0]  ifun,
                                            input logic [3:0]  ra,
                                            input logic [3:0]  rb,
                                            input logic [63:0] valc,
                                            input logic [3:0]  idx);
    logic [3:0] len;
    logic [2:0] vidx;
    len = instr_len(icode);
    if (len == 4'd9) begin
      vidx = 3'(idx - 4'd1);
    end else begin
      vidx = 3'(idx - 4'd2);
    end
    if (idx == 4'd0) begin
      instr_byte = {icode, ifun};
    end else if (idx == 4'd1 && len != 4'd9) begin
      instr_byte = {ra, rb};
    end else begin
      instr_byte = 8'(valc >> {3'd7 - vidx, 3'b000});
    end
  endfunction

endpackage

// File: rtl/instr_len_rom.sv
// Combinational icode decode to instruction length and legality.
module instr_len_rom
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  // Table lookup shared with the fetch stage's valP computation.
  always_comb begin
    len   = instr_len(icode);
    valid = (len != 4'd0);
  end

endmodule

// File: rtl/instr_encoder.sv
// Serialises Y86-64 instruction fields into instruction-memory bytes, one
// byte per cycle, with overflow/illegal-icode screening before emission.
module instr_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MEM_SIZE  = 2048,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              err_invalid,
  output logic              err_overflow,
  output logic [15:0]       instr_count
);

  // One extra pointer bit lets the pointer sit exactly at MEM_SIZE without wrapping.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] BASE_PTR  = PTR_W'(BASE_ADDR);
  localparam logic [PTR_W:0]   MEM_LIMIT = (PTR_W + 1)'(MEM_SIZE);

  enc_state_e        state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [3:0]        idx_r;
  logic [3:0]        len_r;
  logic [3:0]        icode_r;
  logic [3:0]        ifun_r;
  logic [3:0]        ra_r;
  logic [3:0]        rb_r;
  logic [63:0]       valc_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              err_invalid_r;
  logic              err_overflow_r;
  logic [15:0]       instr_count_r;

  logic [3:0]        len_s;
  logic              len_valid_s;
  logic [PTR_W:0]    end_s;
  logic              fits_s;
  logic              last_shown_s;
  logic              in_ready_s;
  logic              hs_s;
  logic              start_s;
  logic              invalid_s;
  logic              ovf_s;
  logic [7:0]        cur_byte_s;

  instr_len_rom u_len_rom (
    .icode (in_icode),
    .len   (len_s),
    .valid (len_valid_s)
  );

  // Handshake qualification; last_shown_s marks the cycle the final byte is on the outputs.
  always_comb begin
    end_s        = {1'b0, ptr_r} + {{(PTR_W - 3){1'b0}}, len_s};
    fits_s       = (end_s <= MEM_LIMIT);
    last_shown_s = (state_r == ST_EMIT) && (idx_r == len_r);
    in_ready_s   = (state_r == ST_IDLE) || (last_shown_s && !wr_stall);
    hs_s         = in_valid && in_ready_s;
    start_s      = hs_s && len_valid_s && fits_s;
    invalid_s    = hs_s && !len_valid_s;
    ovf_s        = hs_s && len_valid_s && !fits_s;
    cur_byte_s   = instr_byte(icode_r, ifun_r, ra_r, rb_r, valc_r, idx_r);
  end

  // Encoder FSM, write pointer, registered write port and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      ptr_r          <= BASE_PTR;
      idx_r          <= 4'd0;
      len_r          <= 4'd0;
      icode_r        <= 4'd0;
      ifun_r         <= 4'd0;
      ra_r           <= 4'd0;
      rb_r           <= 4'd0;
      valc_r         <= 64'd0;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= BASE_PTR[ADDR_W-1:0];
      wr_data_r      <= 8'd0;
      err_invalid_r  <= 1'b0;
      err_overflow_r <= 1'b0;
      instr_count_r  <= 16'd0;
    end else begin
      if (invalid_s) begin
        err_invalid_r <= 1'b1;
      end
      if (ovf_s) begin
        err_overflow_r <= 1'b1;
      end
      if (last_shown_s && instr_count_r != 16'hFFFF) begin
        instr_count_r <= instr_count_r + 16'd1;
      end
      if (start_s) begin
        state_r <= ST_EMIT;
        len_r   <= len_s;
        icode_r <= in_icode;
        ifun_r  <= in_ifun;
        ra_r    <= in_rA;
        rb_r    <= in_rB;
        valc_r  <= in_valC;
        if (!wr_stall) begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= ptr_r[ADDR_W-1:0];
          wr_data_r <= {in_icode, in_ifun};
          ptr_r     <= ptr_r + PTR_W'(1);
          idx_r     <= 4'd1;
        end else begin
          wr_en_r <= 1'b0;
          idx_r   <= 4'd0;
        end
      end else if (state_r == ST_EMIT && !last_shown_s) begin
        if (wr_stall) begin
          wr_en_r <= 1'b0;
        end else begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= ptr_r[ADDR_W-1:0];
          wr_data_r <= cur_byte_s;
          ptr_r     <= ptr_r + PTR_W'(1);
          idx_r     <= idx_r + 4'd1;
        end
      end else begin
        state_r <= ST_IDLE;
        wr_en_r <= 1'b0;
        if (state_r == ST_IDLE && !hs_s && addr_load) begin
          ptr_r <= {1'b0, addr_load_val};
        end
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign busy         = (state_r == ST_EMIT);
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign err_invalid  = err_invalid_r;
  assign err_overflow = err_overflow_r;
  assign instr_count  = instr_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table-driven bench for instr_encoder plus hand-written multi-cycle
// sequences (back-to-back, stall, addr_load, errors, mid-emission reset).
module tb_instr_encoder;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [3:0]        in_rA;
  logic [3:0]        in_rB;
  logic [63:0]       in_valC;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_load_val;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              err_invalid;
  logic              err_overflow;
  logic [15:0]       instr_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .MEM_SIZE(2048), .BASE_ADDR(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_icode      (in_icode),
    .in_ifun       (in_ifun),
    .in_rA         (in_rA),
    .in_rB         (in_rB),
    .in_valC       (in_valC),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val),
    .wr_stall      (wr_stall),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .err_invalid   (err_invalid),
    .err_overflow  (err_overflow),
    .instr_count   (instr_count)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    int          ptr;
    int          len;
    logic [79:0] exp;   // byte0 in bits [79:72]
  } vec_t;

  vec_t vecs[8];

  // Next instruction to present during the last-byte cycle of the current one.
  bit          nxt_pending = 1'b0;
  logic [3:0]  nxt_icode, nxt_ifun, nxt_ra, nxt_rb;
  logic [63:0] nxt_valc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] i, input logic [3:0] f, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] v);
    in_icode = i; in_ifun = f; in_rA = a; in_rB = b; in_valC = v;
    in_valid = 1'b1;
  endtask

  task automatic load_ptr(input int p);
    @(negedge clk);
    addr_load = 1'b1;
    addr_load_val = ADDR_W'(p);
    @(negedge clk);
    addr_load = 1'b0;
  endtask

  // Checks len consecutive written bytes after a handshake at the previous edge.
  task automatic expect_bytes(input logic [79:0] exp, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("wr_en", 64'(wr_en), 64'd1);
      chk("wr_addr", 64'(wr_addr), 64'(base + k));
      chk("wr_data", 64'(wr_data), 64'(exp[79 - 8 * k -: 8]));
      chk("busy", 64'(busy), 64'd1);
      if (k == 0) in_valid = 1'b0;
      if (k == len - 1 && nxt_pending) begin
        send(nxt_icode, nxt_ifun, nxt_ra, nxt_rb, nxt_valc);
        nxt_pending = 1'b0;
        chk("in_ready_last", 64'(in_ready), 64'd1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{4'h3, 4'h0, 4'hF, 4'h0, 64'h4,                  0,    10, 80'h30F0_0000_0000_0000_0004};
    vecs[1] = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h123,                30,   9,  80'h7000_0000_0000_0001_2300};
    vecs[2] = '{4'h8, 4'h0, 4'hF, 4'hF, 64'h123,                40,   9,  80'h8000_0000_0000_0001_2300};
    vecs[3] = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                  50,   1,  80'h0000_0000_0000_0000_0000};
    vecs[4] = '{4'h4, 4'h0, 4'h1, 4'h2, 64'h0102030405060708,   51,   10, 80'h4012_0102_0304_0506_0708};
    vecs[5] = '{4'hA, 4'h0, 4'h7, 4'hF, 64'h0,                  61,   2,  80'hA07F_0000_0000_0000_0000};
    vecs[6] = '{4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                  2047, 1,  80'h9000_0000_0000_0000_0000};
    vecs[7] = '{4'hB, 4'h0, 4'h3, 4'hF, 64'h0,                  2046, 2,  80'hB03F_0000_0000_0000_0000};

    rst = 1'b1; in_valid = 1'b0; in_icode = 4'h0; in_ifun = 4'h0; in_rA = 4'h0; in_rB = 4'h0;
    in_valC = 64'h0; addr_load = 1'b0; addr_load_val = '0; wr_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_err_invalid", 64'(err_invalid), 64'd0);
    chk("rst_err_overflow", 64'(err_overflow), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);

    // Table of single instructions
    for (int v = 0; v < 8; v++) begin
      load_ptr(vecs[v].ptr);
      chk("idle_ready", 64'(in_ready), 64'd1);
      send(vecs[v].icode, vecs[v].ifun, vecs[v].ra, vecs[v].rb, vecs[v].valc);
      expect_bytes(vecs[v].exp, vecs[v].len, vecs[v].ptr);
      @(negedge clk);
      exp_count++;
      chk("count", 64'(instr_count), 64'(exp_count));
      chk("idle_after", 64'(busy), 64'd0);
      chk("wr_en_after", 64'(wr_en), 64'd0);
    end
    chk("no_err_invalid", 64'(err_invalid), 64'd0);
    chk("no_err_overflow", 64'(err_overflow), 64'd0);

    // Back-to-back irmovq $10,%rbx then addq %rax,%rbx
    load_ptr(10);
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'hA);
    nxt_icode = 4'h6; nxt_ifun = 4'h0; nxt_ra = 4'h0; nxt_rb = 4'h3; nxt_valc = 64'h0;
    nxt_pending = 1'b1;
    expect_bytes(80'h30F3_0000_0000_0000_000A, 10, 10);
    expect_bytes(80'h6003_0000_0000_0000_0000, 2, 20);
    @(negedge clk);
    exp_count += 2;
    chk("b2b_count", 64'(instr_count), 64'(exp_count));

    // Stall for three cycles while byte 4 is on the outputs
    load_ptr(100);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("st_wr_en", 64'(wr_en), 64'd1);
      chk("st_wr_addr", 64'(wr_addr), 64'(100 + k));
      chk("st_wr_data", 64'(wr_data), 64'(vecs[0].exp[79 - 8 * k -: 8]));
      if (k == 0) in_valid = 1'b0;
      if (k == 4) begin
        wr_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_wr_en", 64'(wr_en), 64'd0);
          chk("stall_addr", 64'(wr_addr), 64'd104);
          chk("stall_data", 64'(wr_data), 64'h00);
          chk("stall_busy", 64'(busy), 64'd1);
        end
        wr_stall = 1'b0;
      end
    end
    @(negedge clk);
    exp_count++;
    chk("stall_count", 64'(instr_count), 64'(exp_count));

    // addr_load coinciding with the handshake and held through emission is ignored
    load_ptr(300);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h4);
    addr_load = 1'b1;
    addr_load_val = ADDR_W'(500);
    expect_bytes(vecs[0].exp, 10, 300);
    addr_load = 1'b0;
    @(negedge clk);
    exp_count++;
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    expect_bytes(80'h1000_0000_0000_0000_0000, 1, 310);
    @(negedge clk);
    exp_count++;

    // Illegal icode: flag, no write, pointer unchanged
    load_ptr(600);
    send(4'hC, 4'h0, 4'hF, 4'hF, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("inv_flag", 64'(err_invalid), 64'd1);
    chk("inv_wr_en", 64'(wr_en), 64'd0);
    chk("inv_busy", 64'(busy), 64'd0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    expect_bytes(80'h0, 1, 600);
    @(negedge clk);
    exp_count++;
    chk("inv_count", 64'(instr_count), 64'(exp_count));

    // Overflow: 10 bytes at 2040 would cross the end of memory
    load_ptr(2040);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h4);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_wr_en", 64'(wr_en), 64'd0);
    chk("ovf_busy", 64'(busy), 64'd0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    expect_bytes(80'h0, 1, 2040);
    @(negedge clk);
    exp_count++;
    chk("ovf_count", 64'(instr_count), 64'(exp_count));
    chk("sticky_invalid", 64'(err_invalid), 64'd1);

    // Reset while byte 5 is on the outputs
    load_ptr(400);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("pre_rst_addr", 64'(wr_addr), 64'(400 + k));
      if (k == 0) in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst_data", 64'(wr_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    chk("post_rst_count", 64'(instr_count), 64'(exp_count));
    chk("post_rst_inv", 64'(err_invalid), 64'd0);
    chk("post_rst_ovf", 64'(err_overflow), 64'd0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    expect_bytes(80'h0, 1, 0);
    @(negedge clk);
    exp_count++;
    chk("post_rst_halt_count", 64'(instr_count), 64'(exp_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
